// File: rtl/group_sequencer.sv
// Frame scheduler for electrode groups: walks the latched enable mask, optionally
// stimulates each group, blanks for settling, then gates the filter while acquiring samples.
module group_sequencer #(
  parameter int GROUPS            = 10,
  parameter int STIM_CYCLES       = 16,
  parameter int SETTLE_CYCLES     = 8,
  parameter int SAMPLES_PER_GROUP = 4,
  parameter int TIMEOUT           = 255
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic              stop,
  input  logic              continuous,
  input  logic [GROUPS-1:0] group_enable_mask,
  input  logic [GROUPS-1:0] stim_group_mask,
  input  logic              processing_done,
  output logic [3:0]        current_group,
  output logic              filter_enable,
  output logic              stim_active,
  output logic              busy,
  output logic              frame_done,
  output logic              timeout_err
);

  typedef enum logic [2:0] {IDLE, SELECT, STIM, SETTLE, ACQUIRE, NEXT} state_t;

  localparam int            CW          = 16;
  localparam logic [CW-1:0] ONE         = CW'(1);
  localparam logic [CW-1:0] STIM_LAST   = CW'(STIM_CYCLES - 1);
  localparam logic [CW-1:0] SETTLE_LAST = CW'(SETTLE_CYCLES - 1);
  localparam logic [CW-1:0] SMP_LAST    = CW'(SAMPLES_PER_GROUP - 1);
  localparam logic [CW-1:0] TO_LIM      = CW'(TIMEOUT);
  localparam logic [3:0]    LAST_GRP    = 4'(GROUPS - 1);

  state_t              state_q, state_d;
  logic [3:0]          ptr_q, ptr_d;
  logic [3:0]          grp_q, grp_d;
  logic [GROUPS-1:0]   en_q, en_d;
  logic [GROUPS-1:0]   st_q, st_d;
  logic [CW-1:0]       cnt_q, cnt_d;
  logic [CW-1:0]       smp_q, smp_d;
  logic [CW-1:0]       wait_q, wait_d;
  logic                filt_q, filt_d;
  logic                stim_q, stim_d;
  logic                busy_q, busy_d;
  logic                fdone_q, fdone_d;
  logic                terr_q, terr_d;

  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    grp_d   = grp_q;
    en_d    = en_q;
    st_d    = st_q;
    cnt_d   = cnt_q;
    smp_d   = smp_q;
    wait_d  = wait_q;
    terr_d  = terr_q;
    fdone_d = 1'b0;

    case (state_q)
      IDLE: begin
        if (start && !stop) begin
          en_d    = group_enable_mask;
          st_d    = stim_group_mask;
          ptr_d   = 4'd0;
          terr_d  = 1'b0;
          state_d = SELECT;
        end
      end
      SELECT: begin
        cnt_d  = '0;
        smp_d  = '0;
        wait_d = '0;
        if (en_q[ptr_q]) begin
          grp_d   = ptr_q;
          state_d = st_q[ptr_q] ? STIM : ACQUIRE;
        end else begin
          state_d = NEXT;
        end
      end
      STIM: begin
        if (cnt_q >= STIM_LAST) begin
          cnt_d   = '0;
          state_d = (SETTLE_CYCLES == 0) ? ACQUIRE : SETTLE;
        end else begin
          cnt_d = cnt_q + ONE;
        end
      end
      SETTLE: begin
        if (cnt_q >= SETTLE_LAST) begin
          cnt_d   = '0;
          state_d = ACQUIRE;
        end else begin
          cnt_d = cnt_q + ONE;
        end
      end
      ACQUIRE: begin
        // A done pulse restarts the wait window; the timeout only fires on silence.
        if (processing_done) begin
          wait_d = '0;
          if (smp_q >= SMP_LAST) state_d = NEXT;
          else                   smp_d   = smp_q + ONE;
        end else if ((wait_q + ONE) >= TO_LIM) begin
          wait_d  = TO_LIM;
          terr_d  = 1'b1;
          state_d = NEXT;
        end else begin
          wait_d = wait_q + ONE;
        end
      end
      NEXT: begin
        if (ptr_q >= LAST_GRP) begin
          fdone_d = 1'b1;
          if (continuous) begin
            en_d    = group_enable_mask;
            st_d    = stim_group_mask;
            ptr_d   = 4'd0;
            state_d = SELECT;
          end else begin
            state_d = IDLE;
          end
        end else begin
          ptr_d   = ptr_q + 4'd1;
          state_d = SELECT;
        end
      end
      default: state_d = IDLE;
    endcase

    if (stop) begin
      state_d = IDLE;
      fdone_d = 1'b0;
      cnt_d   = '0;
      smp_d   = '0;
      wait_d  = '0;
    end

    filt_d = (state_d == ACQUIRE);
    stim_d = (state_d == STIM);
    busy_d = (state_d != IDLE);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      ptr_q   <= 4'd0;
      grp_q   <= 4'd0;
      en_q    <= '0;
      st_q    <= '0;
      cnt_q   <= '0;
      smp_q   <= '0;
      wait_q  <= '0;
      filt_q  <= 1'b0;
      stim_q  <= 1'b0;
      busy_q  <= 1'b0;
      fdone_q <= 1'b0;
      terr_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      grp_q   <= grp_d;
      en_q    <= en_d;
      st_q    <= st_d;
      cnt_q   <= cnt_d;
      smp_q   <= smp_d;
      wait_q  <= wait_d;
      filt_q  <= filt_d;
      stim_q  <= stim_d;
      busy_q  <= busy_d;
      fdone_q <= fdone_d;
      terr_q  <= terr_d;
    end
  end

  assign current_group = grp_q;
  assign filter_enable = filt_q;
  assign stim_active   = stim_q;
  assign busy          = busy_q;
  assign frame_done    = fdone_q;
  assign timeout_err   = terr_q;

endmodule

// File: tb/tb_group_sequencer.sv
// Bench for group_sequencer: table of whole frames plus random frames, each predicted by a
// per-slot timeline model, followed by hand-written continuous, stop and reset sequences.
module tb_group_sequencer;

  logic       clk = 1'b0;
  logic       reset, start, stop, continuous, processing_done;
  logic [9:0] group_enable_mask, stim_group_mask;
  logic [3:0] current_group;
  logic       filter_enable, stim_active, busy, frame_done, timeout_err;

  int checks   = 0;
  int failures = 0;

  localparam int MAXS = 12000;
  logic [8:0] exp_a  [0:MAXS-1];
  bit         done_a [0:MAXS-1];
  logic [3:0] cur_m;
  logic       terr_m;

  typedef struct {
    logic [9:0] en;
    logic [9:0] st;
    int         period;
    int         exp_len;
    logic       exp_terr;
  } vec_t;
  vec_t tbl [5];
  int   dens_tab [4];

  group_sequencer dut (
    .clk               (clk),
    .reset             (reset),
    .start             (start),
    .stop              (stop),
    .continuous        (continuous),
    .group_enable_mask (group_enable_mask),
    .stim_group_mask   (stim_group_mask),
    .processing_done   (processing_done),
    .current_group     (current_group),
    .filter_enable     (filter_enable),
    .stim_active       (stim_active),
    .busy              (busy),
    .frame_done        (frame_done),
    .timeout_err       (timeout_err)
  );

  always #5 clk = ~clk;

  initial begin
    #900000;
    $display("FAIL watchdog: simulation did not complete act=running exp=finished");
    $fatal(1, "watchdog");
  end

  function automatic logic [8:0] obs();
    return {current_group, filter_enable, stim_active, busy, frame_done, timeout_err};
  endfunction

  function automatic logic [8:0] pk(logic [3:0] cg, logic f, logic s, logic b, logic d, logic t);
    return {cg, f, s, b, d, t};
  endfunction

  task automatic check(input string nm, input logic [15:0] act, input logic [15:0] expv);
    checks++;
    if (act !== expv) begin
      failures++;
      $display("FAIL %s act=%h exp=%h", nm, act, expv);
    end
  endtask

  // Timeline of one frame: slot s is the cycle after the s-th edge following the start edge.
  task automatic build_model(input logic [9:0] en, input logic [9:0] st, output int len);
    int t, n, w;
    t = 0;
    terr_m = 1'b0;
    for (int g = 0; g < 10; g++) begin
      exp_a[t] = pk(cur_m, 0, 0, 1, 0, terr_m); t++;
      if (en[g]) begin
        cur_m = 4'(g);
        if (st[g]) begin
          for (int i = 0; i < 16; i++) begin exp_a[t] = pk(cur_m, 0, 1, 1, 0, terr_m); t++; end
          for (int i = 0; i < 8; i++)  begin exp_a[t] = pk(cur_m, 0, 0, 1, 0, terr_m); t++; end
        end
        n = 0;
        w = 0;
        while (t < MAXS - 4) begin
          exp_a[t] = pk(cur_m, 1, 0, 1, 0, terr_m);
          if (done_a[t]) begin
            n++; w = 0; t++;
            if (n == 4) break;
          end else begin
            w++; t++;
            if (w == 255) begin terr_m = 1'b1; break; end
          end
        end
      end
      exp_a[t] = pk(cur_m, 0, 0, 1, 0, terr_m); t++;
    end
    exp_a[t] = pk(cur_m, 0, 0, 0, 1, terr_m);
    len = t;
  endtask

  task automatic run_frame(input logic [9:0] en, input logic [9:0] st, input int period,
                           input int dens, input int exp_len, input logic exp_terr);
    int len;
    for (int s = 0; s < MAXS; s++) begin
      if (period > 0)    done_a[s] = ((s % period) == period - 1);
      else if (dens > 0) done_a[s] = ($urandom_range(dens - 1, 0) == 0);
      else               done_a[s] = 1'b0;
    end
    build_model(en, st, len);
    @(negedge clk);
    group_enable_mask = en;
    stim_group_mask   = st;
    start             = 1'b1;
    processing_done   = 1'b0;
    @(posedge clk);
    for (int s = 0; s <= len + 3; s++) begin
      @(negedge clk);
      if (s <= len) check($sformatf("slot%0d", s), 16'(obs()), 16'(exp_a[s]));
      else          check($sformatf("idle%0d", s), 16'(obs()),
                          16'({exp_a[len][8:2], 1'b0, exp_a[len][0]}));
      if (s == exp_len)
        check("tbl_end", 16'({frame_done, busy, timeout_err}), 16'({1'b1, 1'b0, exp_terr}));
      if (s < len) begin
        start             = 1'($urandom_range(1, 0));
        group_enable_mask = 10'($urandom);
        stim_group_mask   = 10'($urandom);
        processing_done   = done_a[s];
      end else begin
        start           = 1'b0;
        processing_done = 1'($urandom_range(1, 0));
      end
    end
    processing_done = 1'b0;
  endtask

  initial begin
    int nfd;
    reset = 1'b1; start = 1'b0; stop = 1'b0; continuous = 1'b0; processing_done = 1'b0;
    group_enable_mask = '0; stim_group_mask = '0;
    cur_m = 4'd0; terr_m = 1'b0;

    tbl[0] = '{en: 10'h005, st: 10'h001, period: 10, exp_len: 115, exp_terr: 1'b0};
    tbl[1] = '{en: 10'h000, st: 10'h3FF, period: 1,  exp_len: 20,  exp_terr: 1'b0};
    tbl[2] = '{en: 10'h001, st: 10'h000, period: 0,  exp_len: 275, exp_terr: 1'b1};
    tbl[3] = '{en: 10'h3FF, st: 10'h000, period: 1,  exp_len: 60,  exp_terr: 1'b0};
    tbl[4] = '{en: 10'h200, st: 10'h200, period: 1,  exp_len: 48,  exp_terr: 1'b0};
    dens_tab = '{2, 6, 20, 400};

    repeat (3) @(negedge clk);
    check("reset_hold", 16'(obs()), 16'h0);
    reset = 1'b0;
    @(negedge clk);
    check("reset_release", 16'(obs()), 16'h0);

    for (int i = 0; i < 5; i++)
      run_frame(tbl[i].en, tbl[i].st, tbl[i].period, 0, tbl[i].exp_len, tbl[i].exp_terr);

    for (int i = 0; i < 4; i++)
      run_frame(10'($urandom), 10'($urandom), 0, dens_tab[i], -1, 1'b0);

    // Continuous frames on group 9 only, then stop during acquisition.
    continuous = 1'b1; group_enable_mask = 10'h200; stim_group_mask = 10'h000;
    processing_done = 1'b1;
    @(negedge clk); start = 1'b1;
    @(posedge clk);
    nfd = 0;
    for (int s = 0; s < 100; s++) begin
      @(negedge clk);
      start = 1'b0;
      if (frame_done) begin
        nfd++;
        check("cont_fd_slot", 16'(s), 16'(24 * nfd));
        check("cont_group", 16'(current_group), 16'd9);
        check("cont_busy", 16'(busy), 16'd1);
      end
      if (nfd == 3) break;
    end
    check("cont_frames", 16'(nfd), 16'd3);
    for (int s = 0; s < 30; s++) begin
      if (filter_enable) break;
      @(negedge clk);
    end
    check("cont_in_acq", 16'(filter_enable), 16'd1);
    stop = 1'b1;
    @(negedge clk);
    stop = 1'b0; continuous = 1'b0; processing_done = 1'b0;
    check("stop_idle", 16'({filter_enable, stim_active, busy, frame_done}), 16'h0);
    @(negedge clk);
    check("stop_stays", 16'({filter_enable, stim_active, busy, frame_done}), 16'h0);

    // Busy starts during STIM, then async reset at STIM cycle 5.
    group_enable_mask = 10'h001; stim_group_mask = 10'h001;
    @(negedge clk); start = 1'b1;
    @(posedge clk);
    for (int s = 0; s <= 5; s++) begin
      @(negedge clk);
      start = (s >= 1 && s <= 4);
    end
    start = 1'b0;
    check("stim5_pre_reset", 16'({stim_active, busy}), 16'h3);
    reset = 1'b1;
    #1;
    check("async_reset", 16'(obs()), 16'h0);
    @(negedge clk);
    reset = 1'b0;

    // Same frame, stop at STIM cycle 5 instead.
    @(negedge clk); start = 1'b1;
    @(posedge clk);
    for (int s = 0; s <= 5; s++) begin
      @(negedge clk);
      start = (s >= 1 && s <= 4);
    end
    start = 1'b0;
    check("stim5_pre_stop", 16'({stim_active, busy}), 16'h3);
    stop = 1'b1;
    #1;
    check("stop_not_async", 16'(stim_active), 16'd1);
    @(posedge clk);
    #1;
    stop = 1'b0;
    check("stop_clears", 16'({filter_enable, stim_active, busy, frame_done}), 16'h0);
    repeat (2) @(negedge clk);
    check("stop_no_restart", 16'({busy, frame_done}), 16'h0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
